// File: rtl/bank_stream_reader_if.sv
// Command, bank and stream signals of bank_stream_reader.
// Optional BANK_READER_STRIDE_EN adds the stride command field.
interface bank_stream_reader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
`ifdef BANK_READER_STRIDE_EN
  logic [ADDR_W-1:0] stride;
`endif
  logic              busy;
  logic              done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

`ifdef BANK_READER_STRIDE_EN
  // Reader side
  modport master (
    input  start, base_addr, len, stride, mem_rdata, m_ready,
    output busy, done, mem_we, mem_addr, m_valid, m_data, m_last
  );
  // Environment side (commander, bank, consumer)
  modport slave (
    output start, base_addr, len, stride, mem_rdata, m_ready,
    input  busy, done, mem_we, mem_addr, m_valid, m_data, m_last
  );
`else
  // Reader side
  modport master (
    input  start, base_addr, len, mem_rdata, m_ready,
    output busy, done, mem_we, mem_addr, m_valid, m_data, m_last
  );
  // Environment side (commander, bank, consumer)
  modport slave (
    output start, base_addr, len, mem_rdata, m_ready,
    input  busy, done, mem_we, mem_addr, m_valid, m_data, m_last
  );
`endif
endinterface

// File: rtl/bank_stream_reader.sv
// Read-side initiator for a single-port bank with 1-cycle registered read.
// Walks len words from base_addr, absorbs read latency in a 2-entry skid
// buffer and streams words out on valid/ready at full throughput.
// Optional BANK_READER_STRIDE_EN: per-command address stride (default 1).
module bank_stream_reader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bank_stream_reader_if.master  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_c;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Skid buffer: slot 0 is always the head; slot 1 only valid if slot 0 is
  logic              v0_q, v0_d, v1_q, v1_d;
  logic              l0_q, l0_d, l1_q, l1_d;
  logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;

  logic              pop_c;
  logic              issue_c;
  logic              final_c;
  logic [1:0]        occ_c;

`ifdef BANK_READER_STRIDE_EN
  logic [ADDR_W-1:0] stride_q, stride_d;
  assign stride_c = stride_q;
`else
  assign stride_c = ADDR_W'(1);
`endif

  // Buffer occupancy plus in-flight read bounds how far issue may run ahead
  assign occ_c = 2'(v0_q) + 2'(v1_q) + 2'(inflight_q);

  // Skid buffer next state: pop shifts slot 1 forward, push fills first free slot
  always_comb begin
    v0_d  = v0_q;
    v1_d  = v1_q;
    l0_d  = l0_q;
    l1_d  = l1_q;
    d0_d  = d0_q;
    d1_d  = d1_q;
    pop_c = v0_q & bus.m_ready;
    if (pop_c) begin
      v0_d = v1_q;
      d0_d = d1_q;
      l0_d = l1_q & v1_q;
      v1_d = 1'b0;
      l1_d = 1'b0;
    end
    if (inflight_q) begin
      if (!v0_d) begin
        v0_d = 1'b1;
        d0_d = bus.mem_rdata;
        l0_d = infl_last_q;
      end else begin
        v1_d = 1'b1;
        d1_d = bus.mem_rdata;
        l1_d = infl_last_q;
      end
    end
  end

  // Command FSM: next state, address walk and issue decision
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    issue_c     = 1'b0;
    final_c     = 1'b0;
`ifdef BANK_READER_STRIDE_EN
    stride_d    = stride_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d   = bus.base_addr;
          len_d    = bus.len;
          issued_d = '0;
`ifdef BANK_READER_STRIDE_EN
          stride_d = bus.stride;
`endif
          state_d  = (bus.len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        issue_c = (occ_c < 2'd2) | pop_c;
        if (issue_c) begin
          issued_d = issued_q + CNT_W'(1);
          final_c  = (issued_d == len_q);
          if (final_c) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + stride_c;
          end
        end
      end
      S_DRAIN: begin
        // Finish in the cycle after the last word leaves the buffer
        if (!v0_d && !v1_d) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    inflight_d  = issue_c;
    infl_last_d = issue_c & final_c;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      l0_q        <= 1'b0;
      l1_q        <= 1'b0;
      d0_q        <= '0;
      d1_q        <= '0;
`ifdef BANK_READER_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      l0_q        <= l0_d;
      l1_q        <= l1_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
`ifdef BANK_READER_STRIDE_EN
      stride_q    <= stride_d;
`endif
    end
  end

  assign bus.mem_we   = 1'b0;
  assign bus.mem_addr = addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.m_valid  = v0_q;
  assign bus.m_data   = d0_q;
  assign bus.m_last   = l0_q;

endmodule
